// File: rtl/intdiv_seq.sv
// Sequential signed restoring divider: one quotient bit per clock, truncating
// quotient, remainder carrying the dividend's sign, divide-by-zero and overflow flags.
module intdiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dz_r;
  logic             ovf_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // |most-negative| is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                  input logic             neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(m);
    return neg ? $unsigned(-s) : m;
  endfunction

  // The WIDTH+1-bit compare decides the quotient bit; when it passes the true
  // difference is below the divisor, so its low WIDTH bits are exact.
  assign shifted = {rem_r, dvd_r[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dsr_r};
  assign diff    = shifted[WIDTH-1:0] - dsr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt   <= CNT_INIT;
            state <= (B == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          // On divide-by-zero the dividend magnitude is still intact, so re-signing it yields A.
          Q        <= dz_r ? '1 : apply_sign(dvd_r, q_neg_r);
          R        <= dz_r ? apply_sign(dvd_r, r_neg_r) : apply_sign(rem_r, r_neg_r);
          div_zero <= dz_r;
          overflow <= ovf_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          dvd_r   <= mag(A);
          dsr_r   <= mag(B);
          rem_r   <= '0;
          q_neg_r <= A[WIDTH-1] ^ B[WIDTH-1];
          r_neg_r <= A[WIDTH-1];
          dz_r    <= (B == '0);
          ovf_r   <= (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        end
      end
      CALC: begin
        rem_r <= ge ? diff : shifted[WIDTH-1:0];
        dvd_r <= {dvd_r[WIDTH-2:0], ge};
      end
      default: ;
    endcase
  end

endmodule
